// File: rtl/log_post_sched.sv
// log_post_sched: two-requester scheduler sharing one log post-processing
// datapath, one operation in flight (IDLE -> CALC -> HOLD).
// Optional macro LOG_SCHED_RR_EN: round-robin arbitration instead of
// fixed priority to requester 0.
module log_post_sched #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [37:0]      req0_exp,
    input  logic [24:0]      req0_man,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [37:0]      req1_exp,
    input  logic [24:0]      req1_man,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_value,
    output logic             res_id,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t      state, state_nxt;
    logic        gnt0, gnt1;
    logic        accept;
    logic [37:0] op_exp;
    logic [22:0] op_man;
    logic        op_id;
    logic [37:0] shifted;
    logic [4:0]  lz;
    logic        lz_found;
    logic [36:0] norm;
    logic [31:0] calc_value;
    logic        unused_bits;

`ifdef LOG_SCHED_RR_EN
    // rr_ptr high means requester 1 wins the next contention
    logic rr_ptr;

    // Grant: contention resolved by the round-robin pointer
    always_comb begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
        if (req0_valid && req1_valid) begin
            gnt0 = ~rr_ptr;
            gnt1 = rr_ptr;
        end
    end

    // Pointer moves to the other requester after each accepted handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= gnt0;
        end
    end
`else
    // Grant: fixed priority, requester 0 always wins
    always_comb begin
        gnt0 = req0_valid;
        gnt1 = req1_valid & ~req0_valid;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = gnt0 & ~rst;
                req1_ready = gnt1 & ~rst;
                accept     = (gnt0 | gnt1) & ~rst;
                if (accept) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Post-process datapath: align mantissa, add exponent, normalise
    always_comb begin
        shifted  = {10'b0, op_man, 5'b0} + op_exp;
        lz       = 5'd31;
        lz_found = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (!lz_found && shifted[36 - i]) begin
                lz       = 5'(i);
                lz_found = 1'b1;
            end
        end
        norm       = shifted[36:0] << lz;
        calc_value = {shifted[37], 8'd135 - {3'b000, lz}, norm[35:13]};
    end

    assign unused_bits = ^{req0_man[24:23], req1_man[24:23], norm[36], norm[12:0]};

    // Operand capture, result register and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            op_exp    <= '0;
            op_man    <= '0;
            op_id     <= 1'b0;
            res_value <= '0;
            res_id    <= 1'b0;
            done_cnt  <= '0;
        end else begin
            if (accept) begin
                op_exp <= gnt1 ? req1_exp : req0_exp;
                op_man <= gnt1 ? req1_man[22:0] : req0_man[22:0];
                op_id  <= gnt1;
            end
            if (state == CALC) begin
                res_value <= calc_value;
                res_id    <= op_id;
            end
            if (state == HOLD && res_ready) begin
                done_cnt <= done_cnt + 1'b1;
            end
        end
    end

endmodule
